// File: rtl/ten_gig_eth_mac_0_rx_addr_filter.sv
// Receive-side destination address filter: forwards unicast/broadcast/optional
// multicast or promiscuous frames, drains rejects and runts, counts both.
module ten_gig_eth_mac_0_rx_addr_filter #(
  parameter int COUNT_WIDTH = 32
) (
  input  logic                   rx_axis_fifo_aclk,
  input  logic                   rx_axis_fifo_areset,
  input  logic [63:0]            rx_axis_fifo_tdata,
  input  logic [7:0]             rx_axis_fifo_tkeep,
  input  logic                   rx_axis_fifo_tvalid,
  input  logic                   rx_axis_fifo_tlast,
  output logic                   rx_axis_fifo_tready,
  output logic [63:0]            rx_axis_client_tdata,
  output logic [7:0]             rx_axis_client_tkeep,
  output logic                   rx_axis_client_tvalid,
  output logic                   rx_axis_client_tlast,
  input  logic                   rx_axis_client_tready,
  input  logic [47:0]            unicast_addr,
  input  logic                   promiscuous,
  input  logic                   mcast_en,
  output logic [COUNT_WIDTH-1:0] frames_passed,
  output logic [COUNT_WIDTH-1:0] frames_dropped
);

  typedef enum logic [1:0] {IDLE, PASS, DROP} state_t;

  state_t      state, state_nxt;
  logic        hs, runt, pass_dec, beat_pass, start;
  logic [47:0] da;

  assign da   = rx_axis_fifo_tdata[47:0];
  assign hs   = rx_axis_fifo_tvalid && rx_axis_fifo_tready;
  assign runt = rx_axis_fifo_tlast && (rx_axis_fifo_tkeep[5:0] != 6'h3F);

  // Runt check overrides every pass condition, promiscuous included.
  assign pass_dec = !runt && (promiscuous ||
                              (da == unicast_addr) ||
                              (da == 48'hFFFF_FFFF_FFFF) ||
                              (mcast_en && da[0]));

  assign start     = hs && (state == IDLE);
  assign beat_pass = (start && pass_dec) || (hs && (state == PASS));

  always_comb begin
    state_nxt           = state;
    rx_axis_fifo_tready = !rx_axis_client_tvalid || rx_axis_client_tready;
    case (state)
      IDLE: if (hs && !rx_axis_fifo_tlast) state_nxt = pass_dec ? PASS : DROP;
      PASS: if (hs && rx_axis_fifo_tlast)  state_nxt = IDLE;
      DROP: begin
        rx_axis_fifo_tready = 1'b1;
        if (hs && rx_axis_fifo_tlast) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (rx_axis_fifo_areset) rx_axis_fifo_tready = 1'b0;
  end

  always_ff @(posedge rx_axis_fifo_aclk) begin
    if (rx_axis_fifo_areset) begin
      state                 <= IDLE;
      rx_axis_client_tdata  <= 64'h0;
      rx_axis_client_tkeep  <= 8'h0;
      rx_axis_client_tvalid <= 1'b0;
      rx_axis_client_tlast  <= 1'b0;
      frames_passed         <= '0;
      frames_dropped        <= '0;
    end else begin
      state <= state_nxt;
      if (beat_pass) begin
        rx_axis_client_tdata  <= rx_axis_fifo_tdata;
        rx_axis_client_tkeep  <= rx_axis_fifo_tkeep;
        rx_axis_client_tlast  <= rx_axis_fifo_tlast;
        rx_axis_client_tvalid <= 1'b1;
      end else if (rx_axis_client_tready) begin
        rx_axis_client_tvalid <= 1'b0;
      end
      // Counters stick at all-ones rather than wrapping.
      if (start && pass_dec && (frames_passed != '1))
        frames_passed <= frames_passed + 1'b1;
      if (start && !pass_dec && (frames_dropped != '1))
        frames_dropped <= frames_dropped + 1'b1;
    end
  end

endmodule

// File: tb/tb_ten_gig_eth_mac_0_rx_addr_filter.sv
// Directed bench for the receive address filter, built with 4-bit counters so
// saturation is reachable.
module tb_ten_gig_eth_mac_0_rx_addr_filter;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          areset;
  logic [63:0]   f_tdata;
  logic [7:0]    f_tkeep;
  logic          f_tvalid, f_tlast, f_tready;
  logic [63:0]   c_tdata;
  logic [7:0]    c_tkeep;
  logic          c_tvalid, c_tlast, c_tready;
  logic [47:0]   unicast_addr;
  logic          promiscuous, mcast_en;
  logic [CW-1:0] frames_passed, frames_dropped;

  int checks = 0;
  int errors = 0;
  int waits;

  always #5 clk = ~clk;

  ten_gig_eth_mac_0_rx_addr_filter #(.COUNT_WIDTH(CW)) dut (
    .rx_axis_fifo_aclk    (clk),
    .rx_axis_fifo_areset  (areset),
    .rx_axis_fifo_tdata   (f_tdata),
    .rx_axis_fifo_tkeep   (f_tkeep),
    .rx_axis_fifo_tvalid  (f_tvalid),
    .rx_axis_fifo_tlast   (f_tlast),
    .rx_axis_fifo_tready  (f_tready),
    .rx_axis_client_tdata (c_tdata),
    .rx_axis_client_tkeep (c_tkeep),
    .rx_axis_client_tvalid(c_tvalid),
    .rx_axis_client_tlast (c_tlast),
    .rx_axis_client_tready(c_tready),
    .unicast_addr         (unicast_addr),
    .promiscuous          (promiscuous),
    .mcast_en             (mcast_en),
    .frames_passed        (frames_passed),
    .frames_dropped       (frames_dropped)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Presents one beat, waits (bounded) for acceptance, returns at posedge+1.
  task automatic send(input logic [63:0] d, input logic [7:0] k, input logic l);
    f_tdata = d; f_tkeep = k; f_tlast = l; f_tvalid = 1'b1;
    waits = 0;
    @(negedge clk);
    while (!f_tready && waits < 20) begin
      @(negedge clk);
      waits++;
    end
    if (waits == 20) chk("handshake_timeout", 64'(waits), 64'd0);
    @(posedge clk); #1;
    f_tvalid = 1'b0;
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
  endtask

  initial begin
    areset = 1'b1; f_tdata = '0; f_tkeep = '0; f_tvalid = 1'b0; f_tlast = 1'b0;
    c_tready = 1'b1; unicast_addr = 48'h0605_0403_0201; promiscuous = 1'b0; mcast_en = 1'b0;
    idle_cycle(); idle_cycle();
    chk("rst_tvalid", c_tvalid, 0);
    chk("rst_tdata", c_tdata, 0);
    chk("rst_tkeep", c_tkeep, 0);
    chk("rst_tlast", c_tlast, 0);
    chk("rst_fifo_tready", f_tready, 0);
    chk("rst_passed", frames_passed, 0);
    chk("rst_dropped", frames_dropped, 0);
    areset = 1'b0;
    idle_cycle();

    // Unicast match, 3 beats
    send(64'hAAAA_0605_0403_0201, 8'hFF, 1'b0);
    chk("uc_b1_valid", c_tvalid, 1); chk("uc_b1_data", c_tdata, 64'hAAAA_0605_0403_0201);
    chk("uc_b1_last", c_tlast, 0);   chk("uc_passed", frames_passed, 1);
    send(64'h1111_2222_3333_4444, 8'hFF, 1'b0);
    chk("uc_b2_data", c_tdata, 64'h1111_2222_3333_4444); chk("uc_b2_last", c_tlast, 0);
    send(64'h5555_6666_7777_8888, 8'h0F, 1'b1);
    chk("uc_b3_data", c_tdata, 64'h5555_6666_7777_8888);
    chk("uc_b3_keep", c_tkeep, 8'h0F); chk("uc_b3_last", c_tlast, 1);

    // Non-matching frame dropped, broadcast follows with no gap
    send(64'hBBBB_0000_0000_0002, 8'hFF, 1'b0); chk("nm_b1_valid", c_tvalid, 0);
    chk("nm_dropped", frames_dropped, 1);
    send(64'h0123_4567_89AB_CDEF, 8'hFF, 1'b0); chk("nm_b2_valid", c_tvalid, 0);
    send(64'h0F0F_0F0F_0F0F_0F0F, 8'h03, 1'b1); chk("nm_b3_valid", c_tvalid, 0);
    send(64'h5555_FFFF_FFFF_FFFF, 8'hFF, 1'b0);
    chk("bc_b1_wait", waits, 0); chk("bc_b1_valid", c_tvalid, 1);
    chk("bc_b1_data", c_tdata, 64'h5555_FFFF_FFFF_FFFF);
    send(64'h9999_AAAA_BBBB_CCCC, 8'h3F, 1'b1);
    chk("bc_b2_wait", waits, 0); chk("bc_b2_last", c_tlast, 1);
    chk("bc_passed", frames_passed, 2); chk("bc_dropped", frames_dropped, 1);

    // Multicast with and without mcast_en, then promiscuous
    send(64'h0000_0000_0000_0001, 8'hFF, 1'b1);
    chk("mc_off_valid", c_tvalid, 0); chk("mc_off_dropped", frames_dropped, 2);
    mcast_en = 1'b1;
    send(64'h0000_0000_0000_0001, 8'hFF, 1'b1);
    chk("mc_on_valid", c_tvalid, 1); chk("mc_on_passed", frames_passed, 3);
    mcast_en = 1'b0; promiscuous = 1'b1;
    send(64'h0000_1234_5678_9ABC, 8'hFF, 1'b1);
    chk("pr_valid", c_tvalid, 1); chk("pr_data", c_tdata, 64'h0000_1234_5678_9ABC);
    chk("pr_passed", frames_passed, 4);

    // Runt dropped even in promiscuous; 6 bytes is not a runt
    send(64'h0000_1234_5678_9ABC, 8'h1F, 1'b1);
    chk("runt_valid", c_tvalid, 0); chk("runt_dropped", frames_dropped, 3);
    send(64'h0000_1234_5678_9ABD, 8'h3F, 1'b1);
    chk("six_byte_valid", c_tvalid, 1); chk("six_byte_passed", frames_passed, 5);
    promiscuous = 1'b0;
    idle_cycle();
    chk("drain_valid", c_tvalid, 0);

    // Backpressure: output held stable for 5 cycles, then frame completes
    c_tready = 1'b0;
    send(64'hD1D1_0605_0403_0201, 8'hFF, 1'b0);
    chk("st_b1_valid", c_tvalid, 1); chk("st_fifo_tready", f_tready, 0);
    for (int i = 0; i < 5; i++) begin
      idle_cycle();
      chk("st_hold_data", c_tdata, 64'hD1D1_0605_0403_0201);
      chk("st_hold_valid", c_tvalid, 1);
      chk("st_hold_tready", f_tready, 0);
    end
    c_tready = 1'b1;
    send(64'hD2D2_D2D2_D2D2_D2D2, 8'h7F, 1'b1);
    chk("st_b2_data", c_tdata, 64'hD2D2_D2D2_D2D2_D2D2); chk("st_b2_last", c_tlast, 1);
    chk("st_passed", frames_passed, 6);
    idle_cycle();

    // Dropped frame drains at full rate while client stalls
    c_tready = 1'b0;
    send(64'hEEEE_0000_0000_0004, 8'hFF, 1'b0); chk("dd_b1_wait", waits, 0);
    send(64'hEEEE_EEEE_EEEE_EEEE, 8'hFF, 1'b0); chk("dd_b2_wait", waits, 0);
    send(64'hEEEE_EEEE_EEEE_EEEF, 8'hFF, 1'b1); chk("dd_b3_wait", waits, 0);
    chk("dd_valid", c_tvalid, 0); chk("dd_dropped", frames_dropped, 4);
    c_tready = 1'b1;

    // Drop counter saturation
    for (int i = 0; i < 11; i++) send(64'h0000_0000_0000_0002, 8'h01, 1'b1);
    chk("sat_reach", frames_dropped, 4'hF);
    send(64'h0000_0000_0000_0002, 8'h01, 1'b1);
    send(64'h0000_0000_0000_0002, 8'h01, 1'b1);
    chk("sat_hold", frames_dropped, 4'hF);

    // Reset on beat 2 of a passing frame
    send(64'hF1F1_0605_0403_0201, 8'hFF, 1'b0);
    chk("rs_b1_valid", c_tvalid, 1);
    f_tdata = 64'hF2F2_F2F2_F2F2_F2F2; f_tkeep = 8'hFF; f_tlast = 1'b0; f_tvalid = 1'b1;
    areset = 1'b1;
    @(negedge clk);
    chk("rs_fifo_tready", f_tready, 0);
    @(posedge clk); #1;
    f_tvalid = 1'b0; areset = 1'b0;
    chk("rs_valid", c_tvalid, 0); chk("rs_data", c_tdata, 0);
    chk("rs_passed", frames_passed, 0); chk("rs_dropped", frames_dropped, 0);
    // Non-matching beat after reset must be treated as a frame start and dropped
    send(64'hF3F3_0000_0000_0002, 8'hFF, 1'b1);
    chk("rs_start_valid", c_tvalid, 0); chk("rs_start_dropped", frames_dropped, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
